im_access_arbiter: RTL and testbench
====================================

Name: im_access_arbiter

Overview:
- Sequences and shares the instruction memory (IM) inside the fetch stage between two requesters:
  - the pipeline fetch path, which issues a node address plus a generation tag;
  - the instruction loader, which writes 34-bit instruction words.
- Fetch has priority. A starvation counter guarantees the loader forward progress.
- Tracks in-flight IM reads and returns each instruction to the fetch path with its tag.
- Blocks all access while the IM runs BIST. IM read responses already in flight still complete.

Parameters:
- STARVE_MAX, 8: consecutive denied loader cycles after which the loader wins the next slot (1..255).
- RD_LAT, 1: cycles from IM command register update to valid IM read data (1..4).
- TAG_W, 12: width of the fetch tag (generation field).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- fch_req_i  in  1  fetch request, held until acknowledged
- fch_adr_i  in  14  fetch node address
- fch_tag_i  in  TAG_W  fetch tag
- fch_ack_o  out  1  fetch granted this cycle
- ld_req_i  in  1  loader write request, held until acknowledged
- ld_adr_i  in  14  loader write address
- ld_data_i  in  34  loader write data
- ld_ack_o  out  1  loader granted this cycle
- bist_mode_i  in  1  IM BIST active
- im_adr_o  out  14  registered IM address
- im_wdata_o  out  34  registered IM write data
- im_wen_o  out  2  registered IM write enable; 2'b01 = write, 2'b00 = read/idle
- im_rd_o  out  1  registered IM read strobe
- im_ins_i  in  34  IM read data
- rsp_vld_o  out  1  fetch response valid
- rsp_tag_o  out  TAG_W  tag of the returned instruction
- rsp_ins_o  out  34  returned instruction
- busy_o  out  1  high when any read is in flight or state is not RUN

Behaviour:
- Reset (rst = 0, asynchronous) forces:
  - all outputs to 0;
  - state to RUN;
  - starvation counter to 0;
  - response pipeline cleared.
- States:
  - RUN: normal arbitration.
  - BIST: entered on the clock edge where bist_mode_i = 1. No acks are issued. The IM command registers are forced to idle (im_rd_o = 0, im_wen_o = 0).
  - BIST_EXIT: entered from BIST when bist_mode_i = 0. Lasts exactly one idle cycle with no acks, then returns to RUN.
  - bist_mode_i = 1 in any state moves to BIST on the next edge.
- Arbitration is combinational within a cycle, in RUN only:
  - fch_ack_o = fch_req_i and not (ld_req_i and starve_cnt == STARVE_MAX).
  - ld_ack_o = ld_req_i and not fch_ack_o.
  - In RUN with bist_mode_i = 1 in the same cycle, both acks are 0.
  - At most one ack per cycle.
- Command register update on the edge ending a grant cycle:
  - Fetch grant: im_adr_o = fch_adr_i, im_rd_o = 1, im_wen_o = 2'b00.
  - Loader grant: im_adr_o = ld_adr_i, im_wdata_o = ld_data_i, im_wen_o = 2'b01, im_rd_o = 0.
  - No grant: im_rd_o = 0, im_wen_o = 0. im_adr_o and im_wdata_o hold their values.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, on every cycle with ld_req_i = 1 and ld_ack_o = 0.
  - Clears on a loader grant, or when ld_req_i = 0.
- Response pipeline:
  - A shift register of depth RD_LAT carries {valid, tag}.
  - It is loaded from the fetch grant one edge after the grant, i.e. aligned with im_rd_o.
  - rsp_vld_o is high RD_LAT cycles after im_rd_o was high. rsp_ins_o = im_ins_i in that cycle, passed combinationally. rsp_tag_o comes from the pipeline.
  - The pipeline keeps shifting in every state, so BIST entry drains reads already in flight.
- Hazards:
  - A fetch to an address written in the immediately preceding grant returns the new data. The IM is write-first; the arbiter does no extra forwarding.
- Reset mid-operation discards all in-flight responses. No rsp_vld_o is produced afterwards.

Decomposition:
- Shared package (im_arb_pkg):
  - state encoding: RUN = 2'd0, BIST = 2'd1, BIST_EXIT = 2'd2;
  - IM write-enable constants: IM_WEN_WR = 2'b01, IM_WEN_NONE = 2'b00;
  - node address width constant 14;
  - instruction width constant 34.
- One sub-module, im_rsp_pipe: parameterised {valid, tag} delay line of depth RD_LAT, with asynchronous active-low reset.

Test Plan:
- Fetch only: fch_req with adr 14'h0123, tag 12'hABC -> fch_ack same cycle; im_rd_o = 1 and im_adr_o = 14'h0123 next cycle; rsp_vld_o with tag 12'hABC RD_LAT = 1 cycle later, rsp_ins_o equal to im_ins_i.
- Loader starvation: fch_req and ld_req both held continuously -> 8 fetch acks, then exactly one ld_ack on the 9th cycle with im_wen_o = 2'b01 next cycle; counter restarts at 0.
- Simultaneous requests with starve_cnt < STARVE_MAX -> only fch_ack_o high, never both acks.
- BIST mid-stream: bist_mode_i rises one cycle after a fetch grant -> the pending rsp_vld_o still appears; no acks while BIST is high; exactly one idle cycle after it falls before the next ack.
- Write-then-read: loader writes 34'h2_DEAD_BEEF to 14'h0010, fetch to 14'h0010 next cycle -> returns 34'h2_DEAD_BEEF.
- Reset asserted with 2 reads in flight (RD_LAT = 2) -> all outputs 0 immediately; no rsp_vld_o after rst deasserts.

Source files
------------

// File: rtl/im_arb_pkg.sv
// Shared types and constants for the instruction-memory access arbiter.
// Arbiter state encoding, IM write-enable codes and IM word geometry.
package im_arb_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_BIST      = 2'd1,
    ST_BIST_EXIT = 2'd2
  } arb_state_e;

  localparam logic [1:0] IM_WEN_WR   = 2'b01;
  localparam logic [1:0] IM_WEN_NONE = 2'b00;

  localparam int IM_ADR_W = 14;
  localparam int IM_INS_W = 34;

endpackage

// File: rtl/im_rsp_pipe.sv
// {valid, tag} delay line that tracks IM reads until their data arrives.
// busy_o reports any stage holding a live read.
module im_rsp_pipe #(
  parameter int DEPTH = 1,
  parameter int TAG_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             vld_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0][TAG_W-1:0] tag_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      tag_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign tag_o  = tag_q[DEPTH-1];
  assign busy_o = |vld_q;

endmodule

// File: rtl/im_access_arbiter.sv
// Shares the fetch-stage instruction memory between fetch (priority) and the
// instruction loader, with loader anti-starvation, BIST lockout and tagged read return.
module im_access_arbiter
  import im_arb_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int RD_LAT     = 1,
  parameter int TAG_W      = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fch_req_i,
  input  logic [IM_ADR_W-1:0] fch_adr_i,
  input  logic [TAG_W-1:0]    fch_tag_i,
  output logic                fch_ack_o,
  input  logic                ld_req_i,
  input  logic [IM_ADR_W-1:0] ld_adr_i,
  input  logic [IM_INS_W-1:0] ld_data_i,
  output logic                ld_ack_o,
  input  logic                bist_mode_i,
  output logic [IM_ADR_W-1:0] im_adr_o,
  output logic [IM_INS_W-1:0] im_wdata_o,
  output logic [1:0]          im_wen_o,
  output logic                im_rd_o,
  input  logic [IM_INS_W-1:0] im_ins_i,
  output logic                rsp_vld_o,
  output logic [TAG_W-1:0]    rsp_tag_o,
  output logic [IM_INS_W-1:0] rsp_ins_o,
  output logic                busy_o
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  arb_state_e          state_q, state_d;
  logic [7:0]          starve_q, starve_d;
  logic [IM_ADR_W-1:0] adr_q, adr_d;
  logic [IM_INS_W-1:0] wdata_q, wdata_d;
  logic [1:0]          wen_q, wen_d;
  logic                rd_q, rd_d;
  logic [TAG_W-1:0]    rd_tag_q, rd_tag_d;

  logic                fch_ack;
  logic                ld_ack;
  logic                starved;
  logic                pipe_vld;
  logic [TAG_W-1:0]    pipe_tag;
  logic                pipe_busy;

  assign starved = ld_req_i && (starve_q == STARVE_LIM);

  // Acks are gated by rst so nothing is granted while reset is held.
  always_comb begin
    state_d = state_q;
    fch_ack = 1'b0;
    ld_ack  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (rst && !bist_mode_i) begin
          fch_ack = fch_req_i && !starved;
          ld_ack  = ld_req_i && !fch_ack;
        end
      end
      ST_BIST:      state_d = ST_BIST_EXIT;
      ST_BIST_EXIT: state_d = ST_RUN;
      default:      state_d = ST_RUN;
    endcase
    if (bist_mode_i) begin
      state_d = ST_BIST;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!ld_req_i || ld_ack) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // Address and write data hold when idle; strobes drop every non-grant cycle.
  always_comb begin
    adr_d    = adr_q;
    wdata_d  = wdata_q;
    wen_d    = IM_WEN_NONE;
    rd_d     = 1'b0;
    rd_tag_d = rd_tag_q;
    if (fch_ack) begin
      adr_d    = fch_adr_i;
      rd_d     = 1'b1;
      rd_tag_d = fch_tag_i;
    end else if (ld_ack) begin
      adr_d   = ld_adr_i;
      wdata_d = ld_data_i;
      wen_d   = IM_WEN_WR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      starve_q <= '0;
      adr_q    <= '0;
      wdata_q  <= '0;
      wen_q    <= IM_WEN_NONE;
      rd_q     <= 1'b0;
      rd_tag_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      rd_q     <= rd_d;
      rd_tag_q <= rd_tag_d;
    end
  end

  // Fed from the strobe register, so the pipe output lines up with IM read data.
  im_rsp_pipe #(
    .DEPTH (RD_LAT),
    .TAG_W (TAG_W)
  ) u_rsp_pipe (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (rd_q),
    .tag_i  (rd_tag_q),
    .vld_o  (pipe_vld),
    .tag_o  (pipe_tag),
    .busy_o (pipe_busy)
  );

  assign fch_ack_o  = fch_ack;
  assign ld_ack_o   = ld_ack;
  assign im_adr_o   = adr_q;
  assign im_wdata_o = wdata_q;
  assign im_wen_o   = wen_q;
  assign im_rd_o    = rd_q;
  assign rsp_vld_o  = pipe_vld;
  assign rsp_tag_o  = pipe_vld ? pipe_tag : '0;
  assign rsp_ins_o  = pipe_vld ? im_ins_i : '0;
  assign busy_o     = (state_q != ST_RUN) || rd_q || pipe_busy;

endmodule

// File: tb/tb_im_access_arbiter.sv
// Directed bench for im_access_arbiter: a RD_LAT=1 instance checked cycle by cycle
// from a vector table, plus a RD_LAT=2 instance for latency and mid-flight reset.
module tb_im_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fch_req;
  logic [13:0] fch_adr;
  logic [11:0] fch_tag;
  logic        ld_req;
  logic [13:0] ld_adr;
  logic [33:0] ld_data;
  logic        bist;

  logic        fa1, la1, rd1, rv1, busy1;
  logic [13:0] adr1;
  logic [33:0] wd1, ins1, rins1;
  logic [1:0]  wen1;
  logic [11:0] rtag1;

  logic        fa2, la2, rd2, rv2, busy2;
  logic [13:0] adr2;
  logic [33:0] wd2, ins2, rins2;
  logic [1:0]  wen2;
  logic [11:0] rtag2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  im_access_arbiter #(.STARVE_MAX(8), .RD_LAT(1), .TAG_W(12)) u_dut1 (
    .clk(clk), .rst(rst),
    .fch_req_i(fch_req), .fch_adr_i(fch_adr), .fch_tag_i(fch_tag), .fch_ack_o(fa1),
    .ld_req_i(ld_req), .ld_adr_i(ld_adr), .ld_data_i(ld_data), .ld_ack_o(la1),
    .bist_mode_i(bist),
    .im_adr_o(adr1), .im_wdata_o(wd1), .im_wen_o(wen1), .im_rd_o(rd1), .im_ins_i(ins1),
    .rsp_vld_o(rv1), .rsp_tag_o(rtag1), .rsp_ins_o(rins1), .busy_o(busy1)
  );

  im_access_arbiter #(.STARVE_MAX(8), .RD_LAT(2), .TAG_W(12)) u_dut2 (
    .clk(clk), .rst(rst),
    .fch_req_i(fch_req), .fch_adr_i(fch_adr), .fch_tag_i(fch_tag), .fch_ack_o(fa2),
    .ld_req_i(ld_req), .ld_adr_i(ld_adr), .ld_data_i(ld_data), .ld_ack_o(la2),
    .bist_mode_i(bist),
    .im_adr_o(adr2), .im_wdata_o(wd2), .im_wen_o(wen2), .im_rd_o(rd2), .im_ins_i(ins2),
    .rsp_vld_o(rv2), .rsp_tag_o(rtag2), .rsp_ins_o(rins2), .busy_o(busy2)
  );

  // Write-first IM models: word = {2'b01, 18'h0, address} until overwritten.
  logic [33:0] mem1 [16384];
  logic [33:0] mem2 [16384];
  logic [33:0] m1_q, m2a_q, m2b_q;

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem1[i] = {2'b01, 18'h0, 14'(i)};
      mem2[i] = {2'b01, 18'h0, 14'(i)};
    end
  end

  always @(posedge clk) begin
    if (wen1 == 2'b01) mem1[adr1] <= wd1;
    m1_q <= mem1[adr1];
    if (wen2 == 2'b01) mem2[adr2] <= wd2;
    m2a_q <= mem2[adr2];
    m2b_q <= m2a_q;
  end

  assign ins1 = m1_q;
  assign ins2 = m2b_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fch_req = 1'b0; fch_adr = '0; fch_tag = '0;
    ld_req  = 1'b0; ld_adr  = '0; ld_data = '0;
    bist    = 1'b0;
  endtask

  typedef struct {
    logic        fr, lr, bm;
    logic [13:0] fadr;
    logic [11:0] ftag;
    logic [13:0] ladr;
    logic [33:0] ldat;
    logic        e_fa, e_la, e_rd;
    logic [1:0]  e_wen;
    logic [13:0] e_adr;
    logic [33:0] e_wd;
    logic        e_rv;
    logic [11:0] e_tag;
    logic [33:0] e_ins;
    logic        e_busy;
  } vec_t;

  vec_t tv [18];

  initial begin
    // inputs: fr lr bm fadr ftag ladr ldat | expected: fa la rd wen adr wdata rv tag ins busy
    tv[0]  = '{'0,'0,'0,'0,'0,'0,'0, '0,'0,'0,2'b00,'0,'0, '0,'0,'0, '0};
    tv[1]  = '{1'b1,'0,'0,14'h0123,12'hABC,'0,'0, 1'b1,'0,'0,2'b00,'0,'0, '0,'0,'0, '0};
    tv[2]  = '{'0,'0,'0,'0,'0,'0,'0, '0,'0,1'b1,2'b00,14'h0123,'0, '0,'0,'0, 1'b1};
    tv[3]  = '{'0,'0,'0,'0,'0,'0,'0, '0,'0,'0,2'b00,'0,'0, 1'b1,12'hABC,34'h1_0000_0123, 1'b1};
    tv[4]  = '{'0,'0,'0,'0,'0,'0,'0, '0,'0,'0,2'b00,'0,'0, '0,'0,'0, '0};
    tv[5]  = '{'0,1'b1,'0,'0,'0,14'h0010,34'h2_DEAD_BEEF, '0,1'b1,'0,2'b00,'0,'0, '0,'0,'0, '0};
    tv[6]  = '{1'b1,'0,'0,14'h0010,12'h011,'0,'0, 1'b1,'0,'0,2'b01,14'h0010,34'h2_DEAD_BEEF, '0,'0,'0, '0};
    tv[7]  = '{'0,'0,'0,'0,'0,'0,'0, '0,'0,1'b1,2'b00,14'h0010,'0, '0,'0,'0, 1'b1};
    tv[8]  = '{'0,'0,'0,'0,'0,'0,'0, '0,'0,'0,2'b00,'0,'0, 1'b1,12'h011,34'h2_DEAD_BEEF, 1'b1};
    tv[9]  = '{1'b1,1'b1,'0,14'h0200,12'h200,14'h0020,34'h0_0000_1111, 1'b1,'0,'0,2'b00,'0,'0, '0,'0,'0, '0};
    tv[10] = '{1'b1,1'b1,1'b1,14'h0300,12'h300,14'h0020,34'h0_0000_1111, '0,'0,1'b1,2'b00,14'h0200,'0, '0,'0,'0, 1'b1};
    tv[11] = '{1'b1,1'b1,1'b1,14'h0300,12'h300,14'h0020,34'h0_0000_1111, '0,'0,'0,2'b00,'0,'0, 1'b1,12'h200,34'h1_0000_0200, 1'b1};
    tv[12] = '{1'b1,1'b1,'0,14'h0300,12'h300,14'h0020,34'h0_0000_1111, '0,'0,'0,2'b00,'0,'0, '0,'0,'0, 1'b1};
    tv[13] = '{1'b1,1'b1,'0,14'h0300,12'h300,14'h0020,34'h0_0000_1111, '0,'0,'0,2'b00,'0,'0, '0,'0,'0, 1'b1};
    tv[14] = '{1'b1,1'b1,'0,14'h0300,12'h300,14'h0020,34'h0_0000_1111, 1'b1,'0,'0,2'b00,'0,'0, '0,'0,'0, '0};
    tv[15] = '{'0,1'b1,'0,'0,'0,14'h0030,34'h0_0000_1234, '0,1'b1,1'b1,2'b00,14'h0300,'0, '0,'0,'0, 1'b1};
    tv[16] = '{'0,'0,'0,'0,'0,'0,'0, '0,'0,'0,2'b01,14'h0030,34'h0_0000_1234, 1'b1,12'h300,34'h1_0000_0300, 1'b1};
    tv[17] = '{'0,'0,'0,'0,'0,'0,'0, '0,'0,'0,2'b00,'0,'0, '0,'0,'0, '0};

    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fch_ack", fa1, 0);
    chk("rst_ld_ack", la1, 0);
    chk("rst_im_adr", adr1, 0);
    chk("rst_im_wdata", wd1, 0);
    chk("rst_im_wen", wen1, 0);
    chk("rst_im_rd", rd1, 0);
    chk("rst_rsp_vld", rv1, 0);
    chk("rst_rsp_tag", rtag1, 0);
    chk("rst_rsp_ins", rins1, 0);
    chk("rst_busy", busy1, 0);
    $display("reset: outputs sampled");
    next_cycle();
    rst = 1'b1;

    // Cycle-by-cycle vector table on the RD_LAT=1 instance
    for (int v = 0; v < 18; v++) begin
      fch_req = tv[v].fr; fch_adr = tv[v].fadr; fch_tag = tv[v].ftag;
      ld_req  = tv[v].lr; ld_adr  = tv[v].ladr; ld_data = tv[v].ldat;
      bist    = tv[v].bm;
      @(negedge clk);
      chk($sformatf("vec%0d_fch_ack", v), fa1, tv[v].e_fa);
      chk($sformatf("vec%0d_ld_ack", v), la1, tv[v].e_la);
      chk($sformatf("vec%0d_acks_match_lat2", v), {fa2, la2}, {tv[v].e_fa, tv[v].e_la});
      chk($sformatf("vec%0d_im_rd", v), rd1, tv[v].e_rd);
      chk($sformatf("vec%0d_im_wen", v), wen1, tv[v].e_wen);
      if (tv[v].e_rd || tv[v].e_wen != 2'b00)
        chk($sformatf("vec%0d_im_adr", v), adr1, tv[v].e_adr);
      if (tv[v].e_wen == 2'b01)
        chk($sformatf("vec%0d_im_wdata", v), wd1, tv[v].e_wd);
      chk($sformatf("vec%0d_rsp_vld", v), rv1, tv[v].e_rv);
      if (tv[v].e_rv) begin
        chk($sformatf("vec%0d_rsp_tag", v), rtag1, tv[v].e_tag);
        chk($sformatf("vec%0d_rsp_ins", v), rins1, tv[v].e_ins);
      end
      chk($sformatf("vec%0d_busy", v), busy1, tv[v].e_busy);
      $display("vec %0d: fch_ack=%b ld_ack=%b im_rd=%b im_wen=%b rsp_vld=%b busy=%b",
               v, fa1, la1, rd1, wen1, rv1, busy1);
      next_cycle();
    end

    // Both requesters held: loader wins every 9th cycle, and the count restarts
    for (int c = 1; c <= 18; c++) begin
      fch_req = 1'b1; fch_adr = 14'(c); fch_tag = 12'(c);
      ld_req  = 1'b1; ld_adr  = 14'h0100 + 14'(c); ld_data = 34'(c);
      @(negedge clk);
      chk($sformatf("starve%0d_fch_ack", c), fa1, (c != 9 && c != 18));
      chk($sformatf("starve%0d_ld_ack", c), la1, (c == 9 || c == 18));
      if (c >= 2)
        chk($sformatf("starve%0d_im_wen", c), wen1, (c == 10) ? 2'b01 : 2'b00);
      $display("starve cycle %0d: fch_ack=%b ld_ack=%b im_wen=%b", c, fa1, la1, wen1);
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    chk("starve_last_im_wen", wen1, 2'b01);
    chk("starve_last_im_adr", adr1, 14'h0112);
    $display("starve tail: im_wen=%b im_adr=%h", wen1, adr1);
    next_cycle();
    repeat (4) next_cycle();

    // Single fetch: response latency on both instances
    fch_req = 1'b1; fch_adr = 14'h0042; fch_tag = 12'h0AA;
    @(negedge clk);
    chk("lat_fch_ack", fa1, 1);
    next_cycle();
    idle_inputs();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("lat%0d_rsp_vld_l1", k), rv1, (k == 2));
      chk($sformatf("lat%0d_rsp_vld_l2", k), rv2, (k == 3));
      if (k == 2) begin
        chk("lat_l1_tag", rtag1, 12'h0AA);
        chk("lat_l1_ins", rins1, 34'h1_0000_0042);
      end
      if (k == 3) begin
        chk("lat_l2_tag", rtag2, 12'h0AA);
        chk("lat_l2_ins", rins2, 34'h1_0000_0042);
      end
      $display("latency cycle %0d: rsp_vld lat1=%b lat2=%b", k, rv1, rv2);
      next_cycle();
    end

    // Reset with two reads in flight on the RD_LAT=2 instance
    fch_req = 1'b1; fch_adr = 14'h0050; fch_tag = 12'h051;
    @(negedge clk);
    chk("inflight_ack_a", fa2, 1);
    next_cycle();
    fch_adr = 14'h0060; fch_tag = 12'h061;
    @(negedge clk);
    chk("inflight_ack_b", fa2, 1);
    next_cycle();
    fch_adr = 14'h0070; fch_tag = 12'h071;
    #1;
    chk("inflight_busy", busy2, 1);
    chk("inflight_im_rd", rd2, 1);
    rst = 1'b0;
    #1;
    chk("arst_fch_ack", fa2, 0);
    chk("arst_ld_ack", la2, 0);
    chk("arst_im_rd", rd2, 0);
    chk("arst_im_adr", adr2, 0);
    chk("arst_im_wdata", wd2, 0);
    chk("arst_im_wen", wen2, 0);
    chk("arst_rsp_vld", rv2, 0);
    chk("arst_busy", busy2, 0);
    chk("arst_l1_rsp_vld", rv1, 0);
    chk("arst_l1_im_adr", adr1, 0);
    $display("async reset: lat2 busy=%b im_rd=%b rsp_vld=%b", busy2, rd2, rv2);
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_rsp_vld_l2", k), rv2, 0);
      chk($sformatf("post_rst%0d_rsp_vld_l1", k), rv1, 0);
      $display("post-reset cycle %0d: rsp_vld lat1=%b lat2=%b", k, rv1, rv2);
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
